// File: rtl/noc_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_out_arbiter
// Description : Per-output switch arbiter. Packet-level round-robin with
//               wormhole locking, feeding a single registered flit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_out_arbiter #(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    output logic [NUM_IN-1:0]        gnt,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     locked,
    output logic [2:0]               owner,
    output logic [15:0]              pkt_cnt,
    output logic                     proto_err
);

    localparam logic       c_ST_IDLE   = 1'b0;
    localparam logic       c_ST_LOCKED = 1'b1;
    localparam logic [1:0] c_TYPE_HEAD = 2'b01;

    logic                r_state;
    logic [2:0]          r_ptr;
    logic [2:0]          r_owner;
    logic [FLIT_W-1:0]   r_out_flit;
    logic                r_out_valid;
    logic [15:0]         r_pkt_cnt;
    logic                r_proto_err;

    logic [1:0]          w_type [NUM_IN];
    logic [NUM_IN-1:0]   w_head_ok;
    logic [NUM_IN-1:0]   w_eligible;
    logic                w_slot_free;
    logic                w_idle_err;
    logic                w_found;
    logic                w_owner_req;
    logic [2:0]          w_winner;
    int                  w_idx;
    logic [NUM_IN-1:0]   w_gnt;
    logic                w_any_gnt;
    logic [FLIT_W-1:0]   w_gnt_flit;
    logic [1:0]          w_gnt_type;

    // Type bit 0 set means the flit may open a packet (head or single).
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_type
            assign w_type[gi]    = in_flit[gi*FLIT_W + FLIT_W - 2 +: 2];
            assign w_head_ok[gi] = w_type[gi][0];
        end
    endgenerate

    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_eligible  = (r_state == c_ST_IDLE) ? (req & w_head_ok) : '0;
        w_idle_err  = (r_state == c_ST_IDLE) && (|(req & ~w_head_ok));
        w_found     = 1'b0;
        w_winner    = '0;
        w_idx       = 0;
        w_owner_req = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_IN) begin
                w_idx = w_idx - NUM_IN;
            end
            if (!w_found && w_eligible[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_owner == 3'(i) && req[i]) begin
                w_owner_req = 1'b1;
            end
        end
        if (r_state == c_ST_LOCKED) begin
            w_winner = r_owner;
            w_found  = w_owner_req;
        end
        w_gnt      = '0;
        w_gnt_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rst_n && w_slot_free && w_found && (w_winner == 3'(i))) begin
                w_gnt[i] = 1'b1;
            end
            if (w_winner == 3'(i)) begin
                w_gnt_flit = in_flit[i*FLIT_W +: FLIT_W];
            end
        end
        w_any_gnt  = |w_gnt;
        w_gnt_type = w_gnt_flit[FLIT_W-1 -: 2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
            r_pkt_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_out_flit  <= w_gnt_flit;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_idle_err) begin
                r_proto_err <= 1'b1;
            end

            if (w_any_gnt) begin
                if (r_state == c_ST_IDLE) begin
                    r_ptr <= (w_winner == 3'(NUM_IN - 1)) ? 3'd0 : w_winner + 3'd1;
                    if (w_gnt_type == c_TYPE_HEAD) begin
                        r_state <= c_ST_LOCKED;
                        r_owner <= w_winner;
                    end else begin
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    end
                end else begin
                    // Type bit 1 set closes the packet (tail or single).
                    if (w_gnt_type[1]) begin
                        r_state   <= c_ST_IDLE;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    end else if (w_gnt_type == c_TYPE_HEAD) begin
                        r_proto_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign gnt       = w_gnt;
    assign out_flit  = r_out_flit;
    assign out_valid = r_out_valid;
    assign locked    = (r_state == c_ST_LOCKED);
    assign owner     = r_owner;
    assign pkt_cnt   = r_pkt_cnt;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_out_arbiter
// Description : Directed vector table plus stall and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_out_arbiter;

    localparam int NUM_IN = 5;
    localparam int FLIT_W = 64;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] T = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_IN-1:0]        req;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        gnt;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_valid;
    logic                     out_ready;
    logic                     locked;
    logic [2:0]               owner;
    logic [15:0]              pkt_cnt;
    logic                     proto_err;

    always #5 clk = ~clk;

    noc_out_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_flit(in_flit), .gnt(gnt),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .owner(owner), .pkt_cnt(pkt_cnt), .proto_err(proto_err)
    );

    typedef struct {
        logic            rst_n;
        logic            rdy;
        logic [4:0]      req;
        logic [4:0][1:0] typ;
        logic [4:0]      gnt;
        logic            locked;
        logic [2:0]      owner;
        logic [15:0]     pkt;
        logic            err;
        logic            valid;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] mk(input logic [1:0] t, input int src, input int seq);
        logic [63:0] f;
        f        = '0;
        f[63:62] = t;
        f[15:8]  = 8'(src);
        f[7:0]   = 8'(seq);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic [4:0] rq,
                       input logic [4:0][1:0] ty, input logic [4:0] g, input logic lk,
                       input logic [2:0] own, input logic [15:0] pk, input logic er,
                       input logic vl);
        vec_t v;
        v.rst_n = r;   v.rdy = rdy;   v.req = rq;  v.typ = ty;  v.gnt = g;
        v.locked = lk; v.owner = own; v.pkt = pk;  v.err = er;  v.valid = vl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [4:0] rq,
                         input logic [4:0][1:0] ty, input int seq);
        rst_n     = r;
        out_ready = rdy;
        req       = rq;
        for (int i = 0; i < NUM_IN; i++) begin
            in_flit[i*FLIT_W +: FLIT_W] = mk(ty[i], i, seq);
        end
    endtask

    initial begin
        vec_t        v;
        logic [63:0] exp_flit;
        logic [63:0] mflit;
        logic        mvalid;
        logic        stall;
        logic [4:0]  exp_g;
        int          mp;
        logic [15:0] mpkt;
        int          pat[8] = '{0, 0, 0, 1, 1, 0, 1, 1};

        rst_n = 1'b0; req = '0; in_flit = '0; out_ready = 1'b1;

        // Reset with every input requesting
        add(0, 1, 5'b11111, {S,S,S,S,S}, 5'b00000, 0, 0, 0, 0, 0);
        add(0, 1, 5'b11111, {S,S,S,S,S}, 5'b00000, 0, 0, 0, 0, 0);
        // Round-robin of single flits
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b00001, 0, 0, 1, 0, 1);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b00010, 0, 0, 2, 0, 1);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b00100, 0, 0, 3, 0, 1);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b01000, 0, 0, 4, 0, 1);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b10000, 0, 0, 5, 0, 1);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b00001, 0, 0, 6, 0, 1);
        // Input 2 packet while input 4 waits with a head
        add(1, 1, 5'b10100, {H,S,H,S,S}, 5'b00100, 1, 2, 6, 0, 1);
        add(1, 1, 5'b10100, {H,S,B,S,S}, 5'b00100, 1, 2, 6, 0, 1);
        add(1, 1, 5'b10100, {H,S,B,S,S}, 5'b00100, 1, 2, 6, 0, 1);
        add(1, 1, 5'b10100, {H,S,T,S,S}, 5'b00100, 0, 0, 7, 0, 1);
        add(1, 1, 5'b10000, {H,S,S,S,S}, 5'b10000, 1, 4, 7, 0, 1);
        // Owner tail and another head together
        add(1, 1, 5'b10010, {T,S,S,H,S}, 5'b10000, 0, 0, 8, 0, 1);
        add(1, 1, 5'b00010, {S,S,S,H,S}, 5'b00010, 1, 1, 8, 0, 1);
        add(1, 1, 5'b00010, {S,S,S,T,S}, 5'b00010, 0, 0, 9, 0, 1);
        // Body while idle, then duplicate head while locked
        add(1, 1, 5'b00010, {S,S,S,B,S}, 5'b00000, 0, 0, 9, 1, 0);
        add(1, 1, 5'b00000, {S,S,S,S,S}, 5'b00000, 0, 0, 9, 1, 0);
        add(1, 1, 5'b01000, {S,H,S,S,S}, 5'b01000, 1, 3, 9, 1, 1);
        add(1, 1, 5'b01000, {S,H,S,S,S}, 5'b01000, 1, 3, 9, 1, 1);
        // Reset mid-packet, then arbitration restarts at input 0
        add(0, 1, 5'b01000, {S,B,S,S,S}, 5'b00000, 0, 0, 0, 0, 0);
        add(1, 1, 5'b11111, {S,S,S,S,S}, 5'b00001, 0, 0, 1, 0, 1);

        @(posedge clk); #1;
        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            drive(v.rst_n, v.rdy, v.req, v.typ, n);
            #3;
            chk($sformatf("v%0d gnt", n), 64'(gnt), 64'(v.gnt));
            exp_flit = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (v.gnt[i]) exp_flit = mk(v.typ[i], i, n);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d locked", n), 64'(locked), 64'(v.locked));
            if (v.locked || !v.rst_n) chk($sformatf("v%0d owner", n), 64'(owner), 64'(v.owner));
            chk($sformatf("v%0d pkt_cnt", n), 64'(pkt_cnt), 64'(v.pkt));
            chk($sformatf("v%0d proto_err", n), 64'(proto_err), 64'(v.err));
            chk($sformatf("v%0d out_valid", n), 64'(out_valid), 64'(v.valid));
            if (!v.rst_n) chk($sformatf("v%0d out_flit", n), out_flit, 64'd0);
            else if (v.gnt != 5'b0) chk($sformatf("v%0d out_flit", n), out_flit, exp_flit);
        end

        // Stall sequence continuing from the last vector
        mp     = 1;
        mvalid = 1'b1;
        mflit  = mk(S, 0, vecs.size() - 1);
        mpkt   = 16'd1;
        for (int s = 0; s < 8; s++) begin
            drive(1, pat[s][0], 5'b11111, {S,S,S,S,S}, 100 + s);
            #3;
            stall = mvalid && (pat[s] == 0);
            exp_g = stall ? 5'b0 : (5'b1 << mp);
            chk($sformatf("stall%0d gnt", s), 64'(gnt), 64'(exp_g));
            @(posedge clk); #1;
            if (!stall) begin
                mflit  = mk(S, mp, 100 + s);
                mvalid = 1'b1;
                mpkt   = mpkt + 16'd1;
                mp     = (mp + 1) % NUM_IN;
            end
            chk($sformatf("stall%0d out_flit", s), out_flit, mflit);
            chk($sformatf("stall%0d out_valid", s), 64'(out_valid), 64'(mvalid));
            chk($sformatf("stall%0d pkt_cnt", s), 64'(pkt_cnt), 64'(mpkt));
        end

        // Packet counter wrap
        drive(0, 1, 5'b00000, {S,S,S,S,S}, 0);
        @(posedge clk); #1;
        drive(1, 1, 5'b00001, {S,S,S,S,S}, 0);
        for (int c = 0; c < 65535; c++) begin
            @(posedge clk);
        end
        #1;
        chk("wrap pkt_cnt ffff", 64'(pkt_cnt), 64'hFFFF);
        @(posedge clk); #1;
        chk("wrap pkt_cnt 0", 64'(pkt_cnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
